// File: rtl/btb_update_scheduler.sv
//==============================================================================
// Module      : btb_update_scheduler
// Description : Arbitrates the single BTB address port between fetch reads and
//               buffered, index-coalesced decode target updates.
//               Optional macro: BTB_BYPASS_EN (forward pending targets to fetch).
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module btb_update_scheduler #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             fetch_req,
    input  logic [3:0]       fetch_pc,
    input  logic             upd_valid,
    input  logic [3:0]       upd_pc,
    input  logic [15:0]      upd_target,
    output logic             upd_ready,
    input  logic [15:0]      btb_rdata,
    output logic [3:0]       btb_addr,
    output logic             btb_wen,
    output logic [15:0]      btb_wdata,
    output logic             btb_enable,
    output logic [15:0]      pred_target,
    output logic             fetch_hold,
    output logic [CNT_W-1:0] pend_count
);

    localparam int               c_PTR_W = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] c_FULL  = CNT_W'(DEPTH);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_DRAIN = 2'd1;
    localparam logic [1:0] c_FORCE = 2'd2;

    logic [3:0]         r_pc  [DEPTH];
    logic [15:0]        r_tgt [DEPTH];
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [CNT_W-1:0]   r_count;
    logic [1:0]         r_state;

    logic [c_PTR_W-1:0] w_age [DEPTH];
    logic [DEPTH-1:0]   w_valid;
    logic               w_wslot;
    logic               w_hit;
    logic [c_PTR_W-1:0] w_hit_idx;
    logic [c_PTR_W-1:0] w_hit_age;
    logic               w_not_full;
    logic               w_push;
    logic               w_coal;
    logic [CNT_W-1:0]   w_count_next;
    logic [1:0]         w_state_next;
    logic [3:0]         w_head_pc;
    logic [15:0]        w_head_tgt;

    // Age 0 is the head; an entry is live when its age is below the count.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            w_age[i]   = c_PTR_W'(i) - r_rd_ptr;
            w_valid[i] = CNT_W'(w_age[i]) < r_count;
        end
    end

    assign w_wslot    = !rst && (r_state != c_IDLE) && (!fetch_req || r_state == c_FORCE);
    assign w_head_pc  = r_pc[r_rd_ptr];
    assign w_head_tgt = r_tgt[r_rd_ptr];

    // Youngest live match, ignoring a head that leaves the FIFO this cycle.
    always_comb begin
        w_hit     = 1'b0;
        w_hit_idx = '0;
        w_hit_age = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (w_valid[i] && (r_pc[i] == upd_pc) &&
                !(w_wslot && (c_PTR_W'(i) == r_rd_ptr)) &&
                (!w_hit || (w_age[i] > w_hit_age))) begin
                w_hit     = 1'b1;
                w_hit_idx = c_PTR_W'(i);
                w_hit_age = w_age[i];
            end
        end
    end

    assign w_not_full   = r_count < c_FULL;
    assign upd_ready    = rst || w_not_full || w_hit;
    assign w_push       = !rst && upd_valid && !w_hit && w_not_full;
    assign w_coal       = !rst && upd_valid && w_hit;
    assign w_count_next = r_count + CNT_W'(w_push) - CNT_W'(w_wslot);

    always_comb begin
        w_state_next = c_DRAIN;
        if (w_count_next == '0) begin
            w_state_next = c_IDLE;
        end else if (w_count_next == c_FULL) begin
            w_state_next = c_FORCE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
            r_state  <= c_IDLE;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_wslot) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_count <= w_count_next;
            r_state <= w_state_next;
        end
    end

    // Payload storage needs no reset: liveness comes from the pointers and count.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_pc[r_wr_ptr]  <= upd_pc;
            r_tgt[r_wr_ptr] <= upd_target;
        end
        if (w_coal) begin
            r_tgt[w_hit_idx] <= upd_target;
        end
    end

    assign btb_addr   = w_wslot ? w_head_pc : fetch_pc;
    assign btb_wen    = w_wslot;
    assign btb_wdata  = w_head_tgt;
    assign btb_enable = !rst;
    assign fetch_hold = !rst && (r_state == c_FORCE) && fetch_req;
    assign pend_count = r_count;

`ifdef BTB_BYPASS_EN
    logic        w_byp_hit;
    logic [15:0] w_byp_tgt;
    logic [c_PTR_W-1:0] w_byp_age;

    // The popping head still counts: its write lands only at the clock edge.
    always_comb begin
        w_byp_hit = 1'b0;
        w_byp_tgt = '0;
        w_byp_age = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (w_valid[i] && (r_pc[i] == fetch_pc) &&
                (!w_byp_hit || (w_age[i] > w_byp_age))) begin
                w_byp_hit = 1'b1;
                w_byp_tgt = r_tgt[i];
                w_byp_age = w_age[i];
            end
        end
    end

    assign pred_target = (fetch_req && w_byp_hit) ? w_byp_tgt : btb_rdata;
`else
    assign pred_target = btb_rdata;
`endif

endmodule

`default_nettype wire
